// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the shift arbiter and its shifter datapath.
//   - XLEN_DEF  : default datapath width
//   - shop_e    : shift operation encodings carried on req*_op_i
//   - SHID_*    : requester IDs reported on rsp_id_o
//   - shctl_t   : control fields of one shift request
package shift_arbiter_pkg;

  localparam int unsigned XLEN_DEF = 64;
  localparam int unsigned OP_W     = 2;
  localparam int unsigned CNT_W    = 6;
  localparam int unsigned WCNT_W   = 5;
  localparam int unsigned WORD_W   = 32;

  typedef enum logic [OP_W-1:0] {
    SHOP_SLL = 2'b00,
    SHOP_SRL = 2'b01,
    SHOP_SRA = 2'b10,
    SHOP_RSV = 2'b11
  } shop_e;

  localparam logic SHID_EX  = 1'b0;
  localparam logic SHID_AUX = 1'b1;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic             word;
    logic [CNT_W-1:0] cnt;
  } shctl_t;

endpackage : shift_arbiter_pkg

// File: rtl/alu_shift.sv
// Raw barrel shifter shared by the EX stage and the auxiliary sequencer.
// Word operations shift the low 32 bits by count[4:0] and return them
// zero-extended; no sign extension of word results is done here.
//   sll_i / srl_i / sra_i : one-hot operation select (all zero -> result 0)
//   shift32_valid_i       : 32-bit (*W) operation
//   shift_count_i         : shift amount
//   shift_num_i           : operand
//   shift_result_o        : combinational result
module alu_shift
  import shift_arbiter_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic             sll_i,
  input  logic             srl_i,
  input  logic             sra_i,
  input  logic             shift32_valid_i,
  input  logic [CNT_W-1:0] shift_count_i,
  input  logic [XLEN-1:0]  shift_num_i,
  output logic [XLEN-1:0]  shift_result_o
);

  localparam int unsigned HI_W = XLEN - WORD_W;

  logic [WORD_W-1:0] w_num;
  logic [WCNT_W-1:0] w_cnt;
  logic [WORD_W-1:0] w_res;
  logic [XLEN-1:0]   d_res;

  // Word and doubleword shift results for the selected operation.
  always_comb begin
    w_num = shift_num_i[WORD_W-1:0];
    w_cnt = shift_count_i[WCNT_W-1:0];
    w_res = '0;
    d_res = '0;
    if (sll_i) begin
      w_res = w_num << w_cnt;
      d_res = shift_num_i << shift_count_i;
    end else if (srl_i) begin
      w_res = w_num >> w_cnt;
      d_res = shift_num_i >> shift_count_i;
    end else if (sra_i) begin
      w_res = WORD_W'($signed(w_num) >>> w_cnt);
      d_res = XLEN'($signed(shift_num_i) >>> shift_count_i);
    end
  end

  assign shift_result_o = shift32_valid_i ? {{HI_W{1'b0}}, w_res} : d_res;

endmodule : alu_shift

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one alu_shift between the EX-stage ALU (port 0)
// and a multi-cycle auxiliary unit (port 1). The winning request is shifted
// combinationally, word results are extended from bit 31, and the result is
// captured in a one-entry response register tagged with the winner's ID.
//   clk, rst                    : clock, synchronous active-high reset
//   reqN_valid_i / reqN_ready_o : request handshake, port N
//   reqN_op_i                   : 00 sll, 01 srl, 10 sra, 11 reserved (result 0)
//   reqN_word_i                 : 32-bit (*W) operation
//   reqN_num_i / reqN_cnt_i     : operand and shift count
//   rsp_valid_o / rsp_ready_i   : response handshake
//   rsp_id_o / rsp_data_o       : owning requester and shift result
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter bit          W_SEXT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [OP_W-1:0]  req0_op_i,
  input  logic             req0_word_i,
  input  logic [XLEN-1:0]  req0_num_i,
  input  logic [CNT_W-1:0] req0_cnt_i,

  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [OP_W-1:0]  req1_op_i,
  input  logic             req1_word_i,
  input  logic [XLEN-1:0]  req1_num_i,
  input  logic [CNT_W-1:0] req1_cnt_i,

  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_id_o,
  output logic [XLEN-1:0]  rsp_data_o
);

  localparam int unsigned HI_W = XLEN - WORD_W;

  logic            ptr;
  logic            slot_free;
  logic            winner;
  logic            accept;
  shctl_t          ctl0;
  shctl_t          ctl1;
  shctl_t          win_ctl;
  logic [XLEN-1:0] win_num;
  logic            dec_sll;
  logic            dec_srl;
  logic            dec_sra;
  logic [XLEN-1:0] shift_res;
  logic            ext_bit;
  logic [XLEN-1:0] result;

  // Response register can take a new result when empty or draining this cycle.
  assign slot_free = ~rsp_valid_o | rsp_ready_i;

  // Sole requester wins; on contention the pointer picks.
  always_comb begin
    winner = SHID_EX;
    if (req0_valid_i && req1_valid_i) begin
      winner = ptr;
    end else if (req1_valid_i) begin
      winner = SHID_AUX;
    end
  end

  assign accept       = slot_free & ~rst & (req0_valid_i | req1_valid_i);
  assign req0_ready_o = accept & (winner == SHID_EX);
  assign req1_ready_o = accept & (winner == SHID_AUX);

  // Steer the winner's fields onto the shared shifter.
  assign ctl0    = '{op: req0_op_i, word: req0_word_i, cnt: req0_cnt_i};
  assign ctl1    = '{op: req1_op_i, word: req1_word_i, cnt: req1_cnt_i};
  assign win_ctl = (winner == SHID_AUX) ? ctl1 : ctl0;
  assign win_num = (winner == SHID_AUX) ? req1_num_i : req0_num_i;

  // Reserved op leaves every select low so the shifter returns 0.
  always_comb begin
    dec_sll = 1'b0;
    dec_srl = 1'b0;
    dec_sra = 1'b0;
    case (shop_e'(win_ctl.op))
      SHOP_SLL: dec_sll = 1'b1;
      SHOP_SRL: dec_srl = 1'b1;
      SHOP_SRA: dec_sra = 1'b1;
      default:  ;
    endcase
  end

  alu_shift #(
    .XLEN (XLEN)
  ) u_alu_shift (
    .sll_i           (dec_sll),
    .srl_i           (dec_srl),
    .sra_i           (dec_sra),
    .shift32_valid_i (win_ctl.word),
    .shift_count_i   (win_ctl.cnt),
    .shift_num_i     (win_num),
    .shift_result_o  (shift_res)
  );

  // *W results take their upper half from bit 31 (or zeros when W_SEXT=0).
  assign ext_bit = W_SEXT & shift_res[WORD_W-1];
  assign result  = win_ctl.word ? {{HI_W{ext_bit}}, shift_res[WORD_W-1:0]} : shift_res;

  // Response register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_o <= 1'b0;
      rsp_id_o    <= SHID_EX;
      rsp_data_o  <= '0;
      ptr         <= SHID_EX;
    end else if (accept) begin
      rsp_valid_o <= 1'b1;
      rsp_id_o    <= winner;
      rsp_data_o  <= result;
      ptr         <= ~winner;
    end else if (rsp_ready_i) begin
      rsp_valid_o <= 1'b0;
    end
  end

endmodule : shift_arbiter

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios with literal
// expectations followed by constrained-random traffic, all compared every
// cycle against a behavioural model of the arbiter.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid_i, req1_valid_i;
  logic        req0_ready_o, req1_ready_o;
  logic [1:0]  req0_op_i, req1_op_i;
  logic        req0_word_i, req1_word_i;
  logic [63:0] req0_num_i, req1_num_i;
  logic [5:0]  req0_cnt_i, req1_cnt_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_id_o;
  logic [63:0] rsp_data_o;

  int errors = 0;
  int checks = 0;

  shift_arbiter #(.XLEN(64), .W_SEXT(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid_i (req0_valid_i),
    .req0_ready_o (req0_ready_o),
    .req0_op_i    (req0_op_i),
    .req0_word_i  (req0_word_i),
    .req0_num_i   (req0_num_i),
    .req0_cnt_i   (req0_cnt_i),
    .req1_valid_i (req1_valid_i),
    .req1_ready_o (req1_ready_o),
    .req1_op_i    (req1_op_i),
    .req1_word_i  (req1_word_i),
    .req1_num_i   (req1_num_i),
    .req1_cnt_i   (req1_cnt_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_id_o     (rsp_id_o),
    .rsp_data_o   (rsp_data_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected result from the architectural definition of each shift.
  function automatic logic [63:0] ref_shift(input logic [1:0] op, input logic word,
                                            input logic [63:0] num, input logic [5:0] cnt);
    logic [31:0] w, r32;
    logic [63:0] r64;
    int n;
    if (op == 2'b11) return 64'd0;
    if (word) begin
      w = num[31:0];
      n = int'(cnt) % 32;
      case (op)
        2'b00:   r32 = w << n;
        2'b01:   r32 = w >> n;
        default: r32 = (w >> n) | (w[31] ? ~(32'hFFFF_FFFF >> n) : 32'd0);
      endcase
      return {{32{r32[31]}}, r32};
    end
    n = int'(cnt);
    case (op)
      2'b00:   r64 = num << n;
      2'b01:   r64 = num >> n;
      default: r64 = (num >> n) | (num[63] ? ~(64'hFFFF_FFFF_FFFF_FFFF >> n) : 64'd0);
    endcase
    return r64;
  endfunction

  // Behavioural model: response slot, owner, data and round-robin pointer.
  logic        m_known = 1'b0;
  logic        m_valid, m_id, m_ptr;
  logic [63:0] m_data;
  logic        e_rdy0, e_rdy1;

  always @(negedge clk) begin
    e_rdy0 = 1'b0;
    e_rdy1 = 1'b0;
    if (m_known) begin
      if (!rst && (!m_valid || rsp_ready_i)) begin
        if (req0_valid_i && req1_valid_i) begin
          if (m_ptr) e_rdy1 = 1'b1;
          else       e_rdy0 = 1'b1;
        end else if (req0_valid_i) begin
          e_rdy0 = 1'b1;
        end else if (req1_valid_i) begin
          e_rdy1 = 1'b1;
        end
      end
      chk("model_ready0", 64'(req0_ready_o), 64'(e_rdy0));
      chk("model_ready1", 64'(req1_ready_o), 64'(e_rdy1));
      chk("model_rsp_valid", 64'(rsp_valid_o), 64'(m_valid));
      chk("model_rsp_id", 64'(rsp_id_o), 64'(m_id));
      chk("model_rsp_data", rsp_data_o, m_data);
    end
    if (rst) begin
      m_known = 1'b1;
      m_valid = 1'b0;
      m_id    = 1'b0;
      m_data  = 64'd0;
      m_ptr   = 1'b0;
    end else if (m_known) begin
      if (e_rdy0 || e_rdy1) begin
        m_valid = 1'b1;
        m_id    = e_rdy1;
        m_data  = e_rdy1 ? ref_shift(req1_op_i, req1_word_i, req1_num_i, req1_cnt_i)
                         : ref_shift(req0_op_i, req0_word_i, req0_num_i, req0_cnt_i);
        m_ptr   = ~e_rdy1;
      end else if (rsp_ready_i) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic gen(output logic [1:0] op, output logic word,
                     output logic [63:0] num, output logic [5:0] cnt);
    int sel;
    op   = 2'($urandom_range(0, 3));
    word = 1'($urandom);
    num  = {$urandom, $urandom};
    sel  = int'($urandom_range(0, 3));
    if (sel == 0) num[31] = 1'b1;
    if (sel == 1) num = 64'h8000_0000_0000_0000;
    cnt  = 6'($urandom);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic a0, a1;

  initial begin
    // Reset with both ports requesting.
    rst = 1'b1;
    rsp_ready_i  = 1'b1;
    req0_valid_i = 1'b1; req0_op_i = 2'b10; req0_word_i = 1'b0;
    req0_num_i = 64'h8000_0000_0000_0000; req0_cnt_i = 6'd4;
    req1_valid_i = 1'b1; req1_op_i = 2'b01; req1_word_i = 1'b1;
    req1_num_i = 64'hFFFF_FFFF_8000_0000; req1_cnt_i = 6'd4;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready0", 64'(req0_ready_o), 64'd0);
    chk("rst_ready1", 64'(req1_ready_o), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_rsp_data", rsp_data_o, 64'd0);
    next_cycle();
    rst = 1'b0;

    // First post-reset cycle: port 0 wins contention.
    @(negedge clk);
    chk("first_ready0", 64'(req0_ready_o), 64'd1);
    chk("first_ready1", 64'(req1_ready_o), 64'd0);
    next_cycle();
    req0_valid_i = 1'b0;
    @(negedge clk);
    chk("sra64_valid", 64'(rsp_valid_o), 64'd1);
    chk("sra64_id", 64'(rsp_id_o), 64'd0);
    chk("sra64_data", rsp_data_o, 64'hF800_0000_0000_0000);
    chk("srlw_ready1", 64'(req1_ready_o), 64'd1);
    next_cycle();
    req1_op_i = 2'b10;
    @(negedge clk);
    chk("srlw_id", 64'(rsp_id_o), 64'd1);
    chk("srlw_data", rsp_data_o, 64'h0000_0000_0800_0000);
    chk("sraw_ready1", 64'(req1_ready_o), 64'd1);
    next_cycle();
    req1_op_i = 2'b00; req1_num_i = 64'd1; req1_cnt_i = 6'd31;
    @(negedge clk);
    chk("sraw_id", 64'(rsp_id_o), 64'd1);
    chk("sraw_data", rsp_data_o, 64'hFFFF_FFFF_F800_0000);
    chk("sllw_ready1", 64'(req1_ready_o), 64'd1);
    next_cycle();
    req1_valid_i = 1'b0;
    @(negedge clk);
    chk("sllw_valid", 64'(rsp_valid_o), 64'd1);
    chk("sllw_data", rsp_data_o, 64'hFFFF_FFFF_8000_0000);
    next_cycle();
    @(negedge clk);
    chk("drain_valid", 64'(rsp_valid_o), 64'd0);
    chk("drain_hold_data", rsp_data_o, 64'hFFFF_FFFF_8000_0000);
    next_cycle();

    // Continuous contention: strict alternation, no bubbles.
    req0_valid_i = 1'b1; req0_op_i = 2'b00; req0_word_i = 1'b0; req0_num_i = 64'd1; req0_cnt_i = 6'd1;
    req1_valid_i = 1'b1; req1_op_i = 2'b01; req1_word_i = 1'b0; req1_num_i = 64'h100; req1_cnt_i = 6'd4;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_ready0", 64'(req0_ready_o), 64'((k % 2) == 0));
      chk("rr_ready1", 64'(req1_ready_o), 64'((k % 2) == 1));
      if (k > 0) begin
        chk("rr_valid", 64'(rsp_valid_o), 64'd1);
        chk("rr_id", 64'(rsp_id_o), 64'((k - 1) % 2));
        chk("rr_data", rsp_data_o, ((k - 1) % 2) != 0 ? 64'h10 : 64'h2);
      end
      next_cycle();
    end
    req0_op_i = 2'b10; req0_num_i = 64'h0123_4567_89AB_CDEF; req0_cnt_i = 6'd8;
    req1_valid_i = 1'b0;
    @(negedge clk);
    chk("rr_last_id", 64'(rsp_id_o), 64'd1);
    chk("rr_last_data", rsp_data_o, 64'h10);
    chk("bp_accept0", 64'(req0_ready_o), 64'd1);
    next_cycle();

    // Backpressure: hold the result, block both ports.
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b1; req1_op_i = 2'b11; req1_word_i = 1'b0;
    req1_num_i = 64'hDEAD_BEEF_0000_FFFF; req1_cnt_i = 6'd3;
    rsp_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_valid", 64'(rsp_valid_o), 64'd1);
      chk("bp_id", 64'(rsp_id_o), 64'd0);
      chk("bp_data", rsp_data_o, 64'h0001_2345_6789_ABCD);
      chk("bp_ready0", 64'(req0_ready_o), 64'd0);
      chk("bp_ready1", 64'(req1_ready_o), 64'd0);
      next_cycle();
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_drain_accept1", 64'(req1_ready_o), 64'd1);
    chk("bp_drain_data", rsp_data_o, 64'h0001_2345_6789_ABCD);
    next_cycle();
    req1_valid_i = 1'b0;
    req0_valid_i = 1'b1; req0_op_i = 2'b00; req0_word_i = 1'b0; req0_num_i = 64'd3; req0_cnt_i = 6'd2;
    @(negedge clk);
    chk("rsv_valid", 64'(rsp_valid_o), 64'd1);
    chk("rsv_id", 64'(rsp_id_o), 64'd1);
    chk("rsv_data", rsp_data_o, 64'd0);
    chk("rsv_next_ready0", 64'(req0_ready_o), 64'd1);
    next_cycle();

    // Reset while a response is held; pointer must return to port 0.
    req0_valid_i = 1'b0;
    rsp_ready_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("pre_rst_valid", 64'(rsp_valid_o), 64'd1);
    chk("pre_rst_data", rsp_data_o, 64'hC);
    chk("in_rst_ready0", 64'(req0_ready_o), 64'd0);
    next_cycle();
    rst = 1'b0;
    req0_valid_i = 1'b1;
    req1_valid_i = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 64'(rsp_valid_o), 64'd0);
    chk("post_rst_data", rsp_data_o, 64'd0);
    chk("post_rst_ptr_ready0", 64'(req0_ready_o), 64'd1);
    chk("post_rst_ptr_ready1", 64'(req1_ready_o), 64'd0);
    next_cycle();
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    rsp_ready_i  = 1'b1;

    // Random traffic; requesters hold their fields until accepted.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      a0 = req0_valid_i & req0_ready_o;
      a1 = req1_valid_i & req1_ready_o;
      next_cycle();
      rst = ($urandom_range(0, 199) == 0);
      if (!req0_valid_i || a0) begin
        req0_valid_i = ($urandom_range(0, 99) < 65);
        gen(req0_op_i, req0_word_i, req0_num_i, req0_cnt_i);
      end
      if (!req1_valid_i || a1) begin
        req1_valid_i = ($urandom_range(0, 99) < 65);
        gen(req1_op_i, req1_word_i, req1_num_i, req1_cnt_i);
      end
      rsp_ready_i = ($urandom_range(0, 99) < 70);
    end
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_shift_arbiter

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one `alu_shift` datapath between two requesters: port 0 is the EX-stage ALU; port 1 is a multi-cycle unit (e.g. CSR/bit-manipulation sequencer).
- Round-robin arbitration with valid/ready handshakes on each request port.
- One-entry registered response stage tagged with the winning requester ID.
- Applies RV64 *W sign extension to 32-bit results, which the raw shifter does not do.

Parameters:
- XLEN, `XLEN (64), datapath width, taken from sysconfig.v.
- W_SEXT, 1, 1 = sign-extend bit 31 of word-op results to XLEN; 0 = zero-extend.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high, sampled on rising clk.
- req0_valid_i  in  1  port 0 request valid.
- req0_ready_o  out  1  port 0 request accepted this cycle.
- req0_op_i  in  2  00 sll, 01 srl, 10 sra, 11 reserved.
- req0_word_i  in  1  32-bit (*W) operation.
- req0_num_i  in  XLEN  operand.
- req0_cnt_i  in  6  shift count.
- req1_valid_i / req1_ready_o / req1_op_i / req1_word_i / req1_num_i / req1_cnt_i: same as port 0.
- rsp_valid_o  out  1  result valid.
- rsp_ready_i  in  1  consumer accepts result.
- rsp_id_o  out  1  requester that owns the result.
- rsp_data_o  out  XLEN  shift result.

Behaviour:
- Reset (rst=1 at a clk edge):
  - rsp_valid_o=0, rsp_id_o=0, rsp_data_o=0, priority pointer ptr=0.
  - Any held response is discarded.
  - req*_ready_o are forced 0 while rst=1.
- Slot free: `slot_free = ~rsp_valid_o | rsp_ready_i`. This is combinational and permits back-to-back throughput of 1 op/cycle.
- Grant (combinational, only when slot_free & ~rst):
  - Only one port valid → that port wins.
  - Both valid → port `ptr` wins.
  - reqN_ready_o = 1 only for the winning port; never both 1 in the same cycle.
- Pointer update: on every accepted request, ptr ← ~winner. ptr is unchanged when nothing is accepted.
- Datapath: the winner's fields drive one `alu_shift` instance combinationally.
  - sra_i/srl_i/sll_i are decoded from op.
  - shift32_valid_i = word.
  - shift_count_i = cnt. The shifter itself ignores cnt[5] for word ops; the controller does not mask it.
  - op=11 → all three decode lines 0 → shifter output 0; the result is 0 and the handshake still completes.
- Result formation:
  - word=1: data = {{32{W_SEXT & s[31]}}, s[31:0]}.
  - word=0: data = s.
- Latency:
  - Accept at edge N → rsp_valid_o=1 with data/id registered at edge N.
  - Visible in cycle N+1; 1-cycle latency.
- Response hold:
  - While rsp_valid_o=1 & rsp_ready_i=0: rsp_data_o and rsp_id_o are stable and both req*_ready_o=0.
- Drain without refill: rsp_valid_o & rsp_ready_i with no request accepted → rsp_valid_o←0; data/id hold their last value.
- Simultaneous drain and accept: the register loads the new result and rsp_valid_o stays 1.
- Requester obligation: a valid request must hold all its fields stable until ready. The arbiter does not latch unaccepted requests.
- No combinational path from rsp_ready_i to rsp_data_o. A path from rsp_ready_i to req*_ready_o is permitted.

Decomposition:
- Shared package/header (alongside sysconfig.v):
  - shift op encodings: SHOP_SLL=2'b00, SHOP_SRL=2'b01, SHOP_SRA=2'b10.
  - requester ID constants: SHID_EX=1'b0, SHID_AUX=1'b1.
- One sub-module instance: the existing `alu_shift`. Arbitration, pointer, and response register stay in shift_arbiter.

Test Plan:
- Reset → rsp_valid_o=0, both ready=0 during rst. First cycle after reset with req0 and req1 both valid: req0_ready_o=1, req1_ready_o=0.
- Port 0 sra, word=0, num 0x8000_0000_0000_0000, cnt 4 → next cycle rsp_valid_o=1, id=0, data 0xF800_0000_0000_0000.
- Port 1 word ops on num 0xFFFF_FFFF_8000_0000, cnt 4, issued back-to-back with rsp_ready_i=1:
  - srl → 0x0000_0000_0800_0000.
  - sra → 0xFFFF_FFFF_F800_0000.
  - Then sll with num 1, cnt 31 → 0xFFFF_FFFF_8000_0000.
  - All results carry id=1; 1 result per cycle.
- Both ports valid continuously for 6 cycles, rsp_ready_i=1 → rsp_id_o sequence 0,1,0,1,0,1, with no bubbles.
- Backpressure: result held with rsp_ready_i=0 for 3 cycles → data/id stable, both ready=0. Raise rsp_ready_i while req1 is valid → the held result drains and req1 is accepted in the same cycle.
- op=11 request → result 0, handshake completes. rst asserted while rsp_valid_o=1 → rsp_valid_o=0 after the edge and ptr=0.
